// File: rtl/bram_pkg.sv
// Shared widths and status type for BRAM-backed queue levels.
package bram_pkg;

  localparam int unsigned STATUS_CNT_WIDTH = 16;

  typedef struct packed {
    logic                        full;
    logic                        empty;
    logic [STATUS_CNT_WIDTH-1:0] count;
  } fifo_status_t;

  // Address bits needed to index a RAM of the given depth (minimum 1).
  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Counter bits needed to represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/bram_sdp_core.sv
// Simple dual-port RAM: one write port, one registered read port with enable.
// Only the read-data register is reset so the array maps onto block RAM.
module bram_sdp_core #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [1 << ADDR_WIDTH];

  // Array write, no reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read data, loaded only on a read enable.
  always_ff @(posedge clk) begin
    if (rst)        rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/bram_fifo.sv
// Show-ahead valid/ready FIFO on top of a simple dual-port BRAM.
// The RAM output register doubles as the head slot, hiding read latency.
module bram_fifo
  import bram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned DEPTH      = 256,
  localparam int unsigned ADDR_WIDTH = addr_width(DEPTH),
  localparam int unsigned CNT_WIDTH  = cnt_width(DEPTH)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_wr_valid,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  output logic                  o_wr_ready,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  input  logic                  i_rd_ready,
  output logic [CNT_WIDTH-1:0]  o_count
);

  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(DEPTH);

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CNT_WIDTH-1:0]  ram_cnt, ram_cnt_nxt, count;
  logic                  rd_valid, rd_valid_nxt;
  logic                  push, pop, rd_en;

  assign o_wr_ready = (count < FULL_CNT);
  assign o_rd_valid = rd_valid;
  assign o_count    = count;

  // Handshakes, read issue and next occupancy.
  // ram_cnt tracks entries still in the array; the head slot is counted separately.
  always_comb begin
    push         = i_wr_valid && o_wr_ready;
    pop          = rd_valid && i_rd_ready;
    rd_en        = (ram_cnt != '0) && (!rd_valid || pop);
    ram_cnt_nxt  = ram_cnt;
    if (push && !rd_en)      ram_cnt_nxt = ram_cnt + CNT_WIDTH'(1);
    else if (rd_en && !push) ram_cnt_nxt = ram_cnt - CNT_WIDTH'(1);
    rd_valid_nxt = rd_valid;
    if (rd_en)    rd_valid_nxt = 1'b1;
    else if (pop) rd_valid_nxt = 1'b0;
  end

  // Pointers, occupancy and head-valid state.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ram_cnt  <= '0;
      rd_valid <= 1'b0;
      count    <= '0;
    end else begin
      if (push)  wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_en) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      ram_cnt  <= ram_cnt_nxt;
      rd_valid <= rd_valid_nxt;
      count    <= ram_cnt_nxt + CNT_WIDTH'(rd_valid_nxt);
    end
  end

  bram_sdp_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (CLK),
    .rst     (RST),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (i_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr),
    .rd_data (o_rd_data)
  );

  a_ram_cnt_range : assert property (@(posedge CLK) disable iff (RST) ram_cnt <= FULL_CNT);
  a_count_range   : assert property (@(posedge CLK) disable iff (RST) count <= FULL_CNT);
  a_ram_cnt_le    : assert property (@(posedge CLK) disable iff (RST) ram_cnt <= count);

endmodule

// File: tb/tb_bram_fifo.sv
// Directed bench for bram_fifo with a 4-entry RAM.
module tb_bram_fifo;

  localparam int unsigned DW    = 16;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [DW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          rd_ready;
  logic [2:0]    count;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  bram_fifo #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .CLK        (clk),
    .RST        (rst),
    .i_wr_valid (wr_valid),
    .i_wr_data  (wr_data),
    .o_wr_ready (wr_ready),
    .o_rd_valid (rd_valid),
    .o_rd_data  (rd_data),
    .i_rd_ready (rd_ready),
    .o_count    (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int unsigned in_idx, out_idx, cycles;
    logic        acc, popped, stalled;
    logic [DW-1:0] held;

    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    step(); step();
    rst = 1'b0;

    // Reset state
    check("rst_wr_ready", 32'(wr_ready), 32'd1);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_count",    32'(count),    32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);

    // Single entry: push at T, head visible after T+1
    wr_valid = 1'b1; wr_data = 16'h00A5;
    step();
    wr_valid = 1'b0;
    check("single_not_yet", 32'(rd_valid), 32'd0);
    check("single_cnt_T",   32'(count),    32'd1);
    step();
    check("single_valid", 32'(rd_valid), 32'd1);
    check("single_data",  32'(rd_data),  32'h00A5);
    check("single_count", 32'(count),    32'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    check("single_pop_valid", 32'(rd_valid), 32'd0);
    check("single_pop_count", 32'(count),    32'd0);

    // Full: push 1..4 with consumer stalled, then a rejected 9
    for (int i = 1; i <= 4; i++) begin
      wr_valid = 1'b1; wr_data = DW'(i);
      step();
    end
    check("full_ready", 32'(wr_ready), 32'd0);
    check("full_count", 32'(count),    32'd4);
    wr_data = 16'd9;
    step();
    wr_valid = 1'b0;
    check("full_reject_count", 32'(count), 32'd4);
    rd_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data",  32'(rd_data),  32'(k));
      step();
      if (k == 1) check("full_pop_ready", 32'(wr_ready), 32'd1);
    end
    rd_ready = 1'b0;
    check("drain_empty", 32'(rd_valid), 32'd0);
    check("drain_count", 32'(count),    32'd0);

    // Streaming: push and pop every cycle, 100 words
    in_idx = 0; out_idx = 0; cycles = 0;
    rd_ready = 1'b1;
    while (out_idx < 100 && cycles < 300) begin
      wr_valid = (in_idx < 100);
      wr_data  = DW'(in_idx);
      acc      = wr_valid && wr_ready;
      popped   = rd_valid && rd_ready;
      if (popped) check("stream_data", 32'(rd_data), 32'(out_idx));
      step();
      cycles++;
      if (acc) in_idx++;
      if (popped) out_idx++;
      if (acc && in_idx >= 2) check("stream_count", 32'(count), 32'd2);
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    check("stream_total",  32'(out_idx), 32'd100);
    check("stream_cycles", 32'(cycles),  32'd102);
    check("stream_empty",  32'(count),   32'd0);

    // Wrap with random backpressure, 12 words through a 4-deep RAM
    in_idx = 0; out_idx = 0; cycles = 0; stalled = 1'b0; held = '0;
    while (out_idx < 12 && cycles < 500) begin
      wr_valid = (in_idx < 12) && ($urandom_range(0, 1) == 1);
      wr_data  = DW'(in_idx);
      rd_ready = ($urandom_range(0, 2) != 0);
      if (stalled) begin
        check("wrap_hold_valid", 32'(rd_valid), 32'd1);
        check("wrap_hold_data",  32'(rd_data),  32'(held));
      end
      acc    = wr_valid && wr_ready;
      popped = rd_valid && rd_ready;
      if (popped) check("wrap_data", 32'(rd_data), 32'(out_idx));
      stalled = rd_valid && !rd_ready;
      held    = rd_data;
      step();
      cycles++;
      if (acc) in_idx++;
      if (popped) out_idx++;
    end
    wr_valid = 1'b0; rd_ready = 1'b0;
    step();
    check("wrap_total", 32'(out_idx), 32'd12);
    check("wrap_empty", 32'(count),   32'd0);

    // Mid-operation reset together with a push
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_data = DW'(16'h0100 + i);
      step();
    end
    wr_valid = 1'b0;
    step();
    check("mid_pre_count", 32'(count), 32'd3);
    rst = 1'b1; wr_valid = 1'b1; wr_data = 16'h0077;
    step();
    rst = 1'b0; wr_valid = 1'b0;
    check("mid_rst_count", 32'(count),    32'd0);
    check("mid_rst_valid", 32'(rd_valid), 32'd0);
    check("mid_rst_data",  32'(rd_data),  32'd0);
    wr_valid = 1'b1; wr_data = 16'h0055;
    step();
    wr_valid = 1'b0;
    step();
    check("mid_first_valid", 32'(rd_valid), 32'd1);
    check("mid_first_data",  32'(rd_data),  32'h0055);
    check("mid_first_count", 32'(count),    32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bram_fifo.md
Name: bram_fifo

Overview:
- Show-ahead FIFO that acts as the initiator of the simple dual-port BRAM interface (write enable/address/data plus a read enable/address returning registered read data one cycle later).
- Converts that raw, fixed-latency RAM protocol into valid/ready streams on both sides, so priority-queue levels and tree stages can buffer entries in block RAM without tracking read latency.
- Handles pointer management, occupancy, flow control and read-latency hiding.

Parameters:
- DATA_WIDTH, 32, width of each stored entry.
- DEPTH, 256, total capacity in entries. Must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), RAM address width (derived; not overridden).
- CNT_WIDTH, $clog2(DEPTH+1), occupancy counter width (derived).

Ports:
- CLK  input  1  clock; all logic on the rising edge.
- RST  input  1  synchronous, active-high reset.
- i_wr_valid  input  1  producer offers i_wr_data.
- i_wr_data  input  DATA_WIDTH  entry to enqueue.
- o_wr_ready  output  1  FIFO can accept an entry.
- o_rd_valid  output  1  o_rd_data holds the head entry.
- o_rd_data  output  DATA_WIDTH  head entry (the RAM's registered read data).
- i_rd_ready  input  1  consumer takes the head this cycle.
- o_count  output  CNT_WIDTH  total entries held (RAM plus head slot).

Behaviour:
- Reset (sync, RST=1 at an edge):
  - wr_ptr, rd_ptr and ram_cnt are cleared to 0; o_rd_valid=0; o_count=0; o_rd_data=0.
  - o_wr_ready=1 from the first cycle after reset.
  - RAM contents are not cleared.
  - Reset takes priority over every other event, including a push or pop in the same cycle.
- Push: when i_wr_valid && o_wr_ready, the RAM is written at wr_ptr and wr_ptr increments modulo DEPTH.
- o_wr_ready = (o_count < DEPTH). Capacity is exactly DEPTH entries; there is no same-cycle pop-to-push bypass when full.
- Pop: when o_rd_valid && i_rd_ready, the head is consumed. Pop is ignored when o_rd_valid=0.
- Read issue (combinational): rd_en = (ram_cnt != 0) && (!o_rd_valid || pop).
  - On rd_en, the RAM reads rd_ptr, rd_ptr increments modulo DEPTH, ram_cnt decrements, and o_rd_valid is set at the next edge.
  - Otherwise, a pop clears o_rd_valid.
- ram_cnt: +1 on push, -1 on rd_en; both in the same cycle leaves it unchanged.
- o_count = ram_cnt + o_rd_valid, registered. Range 0..DEPTH.
- Latency: a push accepted at edge T into an empty FIFO gives o_rd_valid=1 after edge T+1, i.e. 2 cycles of write-to-read latency.
- Throughput: with continuous push and pop, one entry per cycle in steady state. No bubbles while ram_cnt > 0.
- No read/write address collision: reads only target entries already written at an earlier edge.
- Stable head: o_rd_data and o_rd_valid hold steady while o_rd_valid && !i_rd_ready. The RAM output register is loaded only on rd_en.
- Wrap-around: pointers wrap naturally at DEPTH. Order is strictly FIFO across any number of wraps.
- Full + pop in the same cycle: the pop is accepted and o_wr_ready rises the next cycle.
- Empty + push in the same cycle as a pop of the last head: the head is consumed; the new entry appears 2 cycles later.
- Assertions: ram_cnt never underflows or overflows; o_count <= DEPTH.

Decomposition:
- bram_pkg: shared constants and helpers, namely the clog2-based width functions and a fifo_status_t struct {full, empty, count}, for use by queue levels.
- Sub-module bram_sdp_core: simple dual-port RAM.
  - Write port and registered read port with read enable.
  - Sync active-high reset applies only to the read-data register; no reset on the array, so it infers as block RAM.
  - bram_fifo instantiates exactly one bram_sdp_core.

Test Plan:
- Reset: after RST → o_wr_ready=1, o_rd_valid=0, o_count=0, o_rd_data=0.
- Single entry: push 0xA5 at edge T with i_rd_ready=0 → o_rd_valid=1 and o_rd_data=0xA5 after T+1, o_count=1. Assert i_rd_ready for one cycle → o_rd_valid=0, o_count=0.
- Full: DEPTH=4, consumer stalled, push 1,2,3,4 → o_wr_ready=0 and o_count=4; a 5th push of 9 is not accepted. Drain yields 1,2,3,4 and never 9.
- Streaming: push and pop every cycle for 100 words 0..99 → after the 2-cycle fill, one word out per cycle, in order, o_count constant.
- Wrap with backpressure: DEPTH=4, 12 words with random i_wr_valid/i_rd_ready → output order 0..11, o_rd_data stable whenever stalled, no loss or duplication.
- Mid-operation reset: 3 entries held, assert RST together with a push → o_count=0, o_rd_valid=0. Then push 0x55 → the first output is 0x55.
